// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data-RAM sequencer (req/ack, lane steering, size/alignment check); done 2 cycles after accept +1 per wait cycle.
// Stalls the pipeline while an access is pending; `define DMC_TIMEOUT_EN adds a REQ timeout abort (error code 10).
module data_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en_in,
  input  logic        r_w_in,
  input  logic [1:0]  size_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        ack_in,
  input  logic [31:0] rdata_in,
  output logic        req_out,
  output logic        we_out,
  output logic [3:0]  be_out,
  output logic [31:0] addr_out,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        err_out,
  output logic [1:0]  err_code_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0] state, state_nxt;
  logic [1:0] lane_q;
  logic       byte_q;
  logic       size_legal, aligned, accept, is_byte;
  logic       timeout_hit;
  logic [7:0] rdata_lane;

  assign is_byte    = (size_in == 2'b00);
  assign size_legal = ~size_in[0];
  assign aligned    = is_byte | (addr_in[1:0] == 2'b00);
  assign accept     = mem_en_in & size_legal & aligned;

`ifdef DMC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Held at zero outside REQ, so every REQ entry starts from a cleared count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != S_REQ) begin
      cnt <= '0;
    end else if (!ack_in) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_REQ) & ~ack_in & (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0 && (TIMEOUT != 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mem_en_in) state_nxt = accept ? S_REQ : S_ERR;
      S_REQ: begin
        if (ack_in)           state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rdata_lane = 8'(rdata_in >> {lane_q, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      we_out       <= 1'b0;
      be_out       <= 4'b0000;
      addr_out     <= 32'h0;
      wdata_out    <= 32'h0;
      rdata_out    <= 32'h0;
      err_code_out <= 2'b00;
      lane_q       <= 2'b00;
      byte_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && mem_en_in) begin
        if (!size_legal) begin
          err_code_out <= 2'b11;
        end else if (!aligned) begin
          err_code_out <= 2'b01;
        end else begin
          we_out    <= r_w_in;
          be_out    <= (r_w_in && is_byte) ? (4'b0001 << addr_in[1:0]) : 4'b1111;
          addr_out  <= {addr_in[31:2], 2'b00};
          wdata_out <= is_byte ? {4{wdata_in[7:0]}} : wdata_in;
          lane_q    <= addr_in[1:0];
          byte_q    <= is_byte;
        end
      end
      if (state == S_REQ && ack_in && !we_out) begin
        rdata_out <= byte_q ? {24'h0, rdata_lane} : rdata_in;
      end
      if (timeout_hit) begin
        err_code_out <= 2'b10;
      end
    end
  end

  assign req_out  = (state == S_REQ);
  assign done_out = (state == S_DONE);
  assign err_out  = (state == S_ERR);
  // Gated by rst_n so a held load/store cannot raise stall while reset is asserted.
  assign stall_out = rst_n & (((state == S_IDLE) & accept) | (state == S_REQ));

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Sequencer for the MEM-stage data-memory port. It takes the load/store control decoded in ID (enable, read/write, size) once the instruction reaches MEM. It runs a req/ack handshake with the data RAM and freezes the pipeline until the access completes, errors, or times out. It also performs byte-lane steering and alignment/size checking.

## Interface
- `TIMEOUT`, 15: max cycles in REQ without `ack_in` before abort (≥1).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_en_in` input 1: MEM-stage instruction is a load/store (LI control bit).
- `r_w_in` input 1: 0 = read (load), 1 = write (store).
- `size_in` input 2: 00 = byte, 10 = word; 01/11 illegal.
- `addr_in` input 32: effective address.
- `wdata_in` input 32: store data (byte stores use bits [7:0]).
- `ack_in` input 1: RAM completion; read data valid same cycle.
- `rdata_in` input 32: RAM read data.
- `req_out` output 1: access request to RAM.
- `we_out` output 1: write enable, valid with `req_out`.
- `be_out` output 4: byte enables, valid with `req_out`.
- `addr_out` output 32: word-aligned address ({addr[31:2],2'b00}).
- `wdata_out` output 32: lane-steered store data.
- `rdata_out` output 32: load result, zero-extended for byte.
- `stall_out` output 1: freeze IF/ID/EX/MEM registers.
- `done_out` output 1: one-cycle pulse, access complete.
- `err_out` output 1: one-cycle pulse, access aborted.
- `err_code_out` output 2: 01 misaligned, 10 timeout, 11 illegal size; holds until next error.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - `mem_en_in` with illegal size → ERR (code 11).
  - Word with `addr_in[1:0]`≠0 → ERR (code 01).
  - Otherwise capture addr/wdata/r_w/size → REQ.
  - `ack_in` in IDLE is ignored.
- REQ: `req_out`=1; `we_out`, `be_out`, `addr_out` and `wdata_out` stay stable from the captured values until ack.
  - On `ack_in`: for a read, latch `rdata_out`; → DONE.
- DONE: `done_out`=1, `stall_out`=0; pipeline advances this cycle. `mem_en_in` is ignored (still the completed instruction). → IDLE.
- ERR: `err_out`=1, `stall_out`=0, no request issued; `rdata_out` unchanged. → IDLE.
- Lane rules, with k=addr[1:0]:
  - Byte write: `be_out`=1<<k; `wdata_out`={4{wdata[7:0]}}.
  - Word write: `be_out`=1111; `wdata_out`=wdata.
  - Reads drive `be_out`=1111.
  - Byte read: `rdata_out`={24'b0, rdata_in[8k+7:8k]}.
  - Word read: `rdata_out`=rdata_in.
- Stores leave `rdata_out` unchanged.

## Timing
- `stall_out` = (IDLE & `mem_en_in` & legal & aligned) | REQ. It is combinational, so the pipeline freezes in the same cycle the access is seen.
- Minimum latency with ack in the first REQ cycle: IDLE→REQ→DONE, 2 cycles from `mem_en_in` to `done_out`. Each wait cycle adds 1.
- Back-to-back accesses: next access is accepted in IDLE the cycle after DONE. Throughput is at most one access per 3 cycles.
- Illegal or misaligned access: `err_out` the cycle after detection. `stall_out` is never asserted for it.
- Timeout counter:
  - Cleared on REQ entry; increments each REQ cycle without ack.
  - When the count equals `TIMEOUT` with no ack: → ERR (code 10), `req_out` drops.
  - Ack arriving in the same cycle as the limit wins → DONE.
- Reset (async, any state): state IDLE; `req_out`, `we_out`, `stall_out`, `done_out`, `err_out` = 0; `be_out`=0000, `addr_out`/`wdata_out`/`rdata_out`=0, `err_code_out`=00, counter 0.
- Reset mid-REQ drops `req_out` immediately. A late `ack_in` after reset is ignored.

## Configuration
- `DMC_TIMEOUT_EN` defined: timeout counter and error code 10 are present as described.
- Not defined: no counter, and REQ waits indefinitely for `ack_in`. Code 10 never occurs, and `TIMEOUT` is unused.

## Test plan
- Word load, `addr_in`=0x104, ack on first REQ cycle, `rdata_in`=0xDEADBEEF:
  - `req_out` 1 cycle, `stall_out` 2 cycles.
  - `done_out` at cycle 2; `rdata_out`=0xDEADBEEF.
- Byte store, `addr_in`=0x203, `wdata_in`=0x000000A5, ack after 3 wait cycles:
  - `be_out`=1000, `wdata_out`=0xA5A5A5A5, `addr_out`=0x200.
  - Stall for 5 cycles.
- Byte load, `addr_in`=0x12, `rdata_in`=0x11223344: `rdata_out`=0x00000022.
- Word access at 0x102: `err_out` pulse, `err_code_out`=01, no `req_out`, no stall.
- Access with `size_in`=01: `err_out` pulse, `err_code_out`=11, no `req_out`.
- With `DMC_TIMEOUT_EN` and `TIMEOUT`=4, no ack:
  - `req_out` drops and `err_code_out`=10.
  - A repeat run with ack on the limit cycle gives `done_out` instead.
  - Assert `rst_n` low mid-REQ: all outputs return to 0 asynchronously.
